ifu: RTL

Instruction fetch unit sitting directly upstream of the single-cycle core. It accepts a fetch request carrying the core's current PC and issues a read on a valid/ready instruction-memory bus. It returns the 32-bit instruction word with a one-cycle valid pulse, holding it stable until the next fetch completes. Misaligned PCs and bus errors are reported as a fetch fault instead of a bus transaction or a silent bad instruction.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_hit_buf.sv | 42 ++++
 rtl/ifu.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] NOP_INST  = 32'h00000013;

endpackage

// File: rtl/ifu_hit_buf.sv
// Single-entry {tag, word, valid} instruction buffer used by ifu when IFU_HIT_BUF_EN is defined.
module ifu_hit_buf
    import ifu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);

    logic                  valid;
    logic [ADDR_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0] word;

    // A flush coinciding with a fill wins: after fence.i nothing older may survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            word  <= fill_data;
        end
    end

    // A flush in the lookup cycle already suppresses the hit.
    assign hit      = valid && !flush && (lookup_addr == tag);
    assign hit_data = word;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch at a time over a valid/ready read bus, with fault reporting.
// Optional single-entry hit buffer enabled by defining IFU_HIT_BUF_EN.
module ifu
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_INST = NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetch_req,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  fetch_fault,
    output logic                  busy,
    output logic                  imem_arvalid,
    output logic [ADDR_WIDTH-1:0] imem_araddr,
    input  logic                  imem_arready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic [1:0]            imem_rresp,
    output logic                  imem_rready
);

    // Bus handshake: a beat transfers on any rising edge where valid and ready are both high;
    // the master holds arvalid/araddr unchanged from assertion until that edge.
    ifu_state_e            state, state_next;
    logic                  fault;
    logic                  misaligned;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic                  rsp_okay;

    assign misaligned = (pc[1:0] != 2'b00);
    assign rsp_okay   = (imem_rresp == RESP_OKAY);

`ifdef IFU_HIT_BUF_EN
    logic buf_fill;

    assign buf_fill = (state == RD) && imem_rvalid && rsp_okay;

    ifu_hit_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hit_buf (
        .clk         (clk),
        .rst         (rst),
        .fill        (buf_fill),
        .fill_addr   (imem_araddr),
        .fill_data   (imem_rdata),
        .flush       (flush),
        .lookup_addr (pc),
        .hit         (hit),
        .hit_data    (hit_data)
    );
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign hit          = 1'b0;
    assign hit_data     = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    state_next = (misaligned || hit) ? RESP : AR;
                end
            end
            AR: begin
                if (imem_arready) begin
                    state_next = RD;
                end
            end
            RD: begin
                if (imem_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // inst only changes on an OKAY bus response or a buffer hit; faults leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst        <= RESET_INST;
            fault       <= 1'b0;
            imem_araddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        fault <= misaligned;
                        if (!misaligned && hit) begin
                            inst <= hit_data;
                        end else if (!misaligned) begin
                            imem_araddr <= pc;
                        end
                    end
                end
                RD: begin
                    if (imem_rvalid) begin
                        fault <= !rsp_okay;
                        if (rsp_okay) begin
                            inst <= imem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign imem_arvalid = (state == AR);
    assign imem_rready  = (state == RD);
    assign inst_valid   = (state == RESP);
    assign fetch_fault  = (state == RESP) && fault;

endmodule
